ifu_fetch: RTL and testbench

//  - Instruction fetch stage upstream of the decode/control path; owns the architectural PC.
//  - Issues word fetches to instruction memory over a request/response handshake.
//  - Holds each fetched word with its PC and presents it to decode over valid/ready.
//  - Accepts redirects (branch/jump targets) from execute; any fetch still in flight is squashed.

---
 rtl/ifu_fetch.sv | 148 ++++++++++++++
 tb/tb_ifu_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage that owns the PC and keeps one imem transaction outstanding.
// Optional IFU_MISALIGN_CHK_EN: a misaligned redirect sets a sticky misalign flag and halts fetch.
module ifu_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             misalign
);

  localparam int unsigned INST_W = 32;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [WIDTH-1:0]    inst_pc_q, inst_pc_d;
  logic                req_valid_q, req_valid_d;
  logic                inst_valid_q, inst_valid_d;
  logic [WIDTH-1:0]    redir_tgt;
  logic                req_fire;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  logic redir_bad;

  assign redir_tgt = redirect_pc;
  assign redir_bad = |redirect_pc[1:0];
  assign misalign  = misalign_q;
`else
  logic unused_redir_lsb;

  // Without the check, low target bits are simply cleared.
  assign redir_tgt        = {redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign misalign         = 1'b0;
`endif

  assign req_fire       = req_valid_q & imem_req_ready;
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Next-state, PC and holding-register logic; redirect overrides everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif

    unique case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          pc_d    = pc_q + WIDTH'(4);
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
`ifdef IFU_MISALIGN_CHK_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      pc_d      = redir_tgt;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      unique case (state_q)
        S_REQ:          state_d = req_fire ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_OUT:          state_d = S_REQ;
        default:        state_d = state_q;
      endcase
`ifdef IFU_MISALIGN_CHK_EN
      if (redir_bad) begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end
`endif
    end

    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_OUT);
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a scoreboard of expected {inst, inst_pc} pairs.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  ifu_fetch #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .misalign        (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] addr);
    chk("req_valid", 64'(imem_req_valid), 64'd1);
    chk("req_addr", 64'(imem_req_addr), 64'(addr));
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_no_req", 64'(imem_req_valid), 64'd0);
  endtask

  task automatic respond(input logic [31:0] addr, input logic [31:0] data);
    sb_q.push_back('{word: data, pc: addr});
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  task automatic consume(input logic redir, input logic [31:0] tgt);
    exp_t e;
    chk("inst_valid", 64'(inst_valid), 64'd1);
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("inst", 64'(inst), 64'(e.word));
      chk("inst_pc", 64'(inst_pc), 64'(e.pc));
    end
    inst_ready     = 1'b1;
    redirect_valid = redir;
    redirect_pc    = tgt;
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    chk({tag, "_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, "_addr"}, 64'(imem_req_addr), 64'(addr));
    chk({tag, "_no_inst"}, 64'(inst_valid), 64'd0);
  endtask

  initial begin
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'h8000_0000);
    chk("rst_addr", 64'(imem_req_addr), 64'h8000_0000);
    chk("rst_misalign", 64'(misalign), 64'd0);
    rst = 1'b1;
    chk("release_no_req", 64'(imem_req_valid), 64'd0);
    tick();

    // 1: basic fetch with minimum latency
    issue(32'h8000_0000);
    respond(32'h8000_0000, 32'h0000_0013);
    consume(1'b0, 32'h0);
    expect_req("t1_next", 32'h8000_0004);

    // 2: decode stalls for 5 cycles
    issue(32'h8000_0004);
    respond(32'h8000_0004, 32'hA5A5_0001);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(inst_valid), 64'd1);
      chk("t2_hold_inst", 64'(inst), 64'hA5A5_0001);
      chk("t2_hold_pc", 64'(inst_pc), 64'h8000_0004);
      chk("t2_no_req", 64'(imem_req_valid), 64'd0);
      chk("t2_pc_stable", 64'(imem_req_addr), 64'h8000_0004);
      tick();
    end
    consume(1'b0, 32'h0);
    expect_req("t2_next", 32'h8000_0008);

    // 3: redirect while waiting; stale response arrives later
    issue(32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t3_drop_no_req", 64'(imem_req_valid), 64'd0);
      chk("t3_drop_no_inst", 64'(inst_valid), 64'd0);
      tick();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    expect_req("t3_after_drop", 32'h8000_0100);
    issue(32'h8000_0100);
    respond(32'h8000_0100, 32'h1111_1111);
    consume(1'b0, 32'h0);

    // 4: redirect together with consume
    issue(32'h8000_0104);
    respond(32'h8000_0104, 32'h2222_2222);
    consume(1'b1, 32'h8000_0040);
    expect_req("t4_redir", 32'h8000_0040);

    // Redirect in the same cycle as the response: word discarded
    issue(32'h8000_0040);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h3333_3333;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h8000_0080;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    expect_req("wait_resp_redir", 32'h8000_0080);

    // Redirect in the same cycle as the request handshake: request is stale
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("req_redir_drop", 64'(imem_req_valid), 64'd0);
    chk("req_redir_pc", 64'(imem_req_addr), 64'h8000_0200);
    tick();
    chk("req_redir_still_drop", 64'(imem_req_valid), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h4444_4444;
    tick();
    imem_resp_valid = 1'b0;
    expect_req("req_redir_after", 32'h8000_0200);

    // 5: PC wraps at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    expect_req("t5_redir", 32'hFFFF_FFFC);
    issue(32'hFFFF_FFFC);
    respond(32'hFFFF_FFFC, 32'h5555_5555);
    consume(1'b0, 32'h0);
    expect_req("t5_wrap", 32'h0000_0000);

    // Reset mid-transaction; response after release is ignored
    issue(32'h0000_0000);
    rst = 1'b0;
    #1;
    chk("midrst_req", 64'(imem_req_valid), 64'd0);
    chk("midrst_addr", 64'(imem_req_addr), 64'h8000_0000);
    @(negedge clk);
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h6666_6666;
    tick();
    imem_resp_valid = 1'b0;
    expect_req("midrst_after", 32'h8000_0000);
    tick();
    chk("midrst_no_inst", 64'(inst_valid), 64'd0);

    // 6: misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    chk("t6_misalign", 64'(misalign), 64'd1);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_halt_no_req", 64'(imem_req_valid), 64'd0);
      chk("t6_halt_no_inst", 64'(inst_valid), 64'd0);
      tick();
    end
    imem_req_ready = 1'b0;
    chk("t6_sticky", 64'(misalign), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_clear", 64'(misalign), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    expect_req("t6_restart", 32'h8000_0000);
`else
    chk("t6_misalign", 64'(misalign), 64'd0);
    expect_req("t6_aligned", 32'h8000_0100);
`endif
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
